traffic_phase_sequencer: RTL
============================

// Module: traffic_phase_sequencer
// PURPOSE
//   Drives the load/down side of the 7-bit countdown timer and consumes its count.
//   Steps a two-road intersection through a fixed phase cycle, one timed phase per timer expiry.
//   Sits between the 1 Hz tick generator and the lamp drivers.
// PARAMETERS
//   COUNT_SIZE   7   width of timer load value / count
//   GREEN_TIME   30  ticks spent in NS_GREEN and in EW_GREEN
//   YELLOW_TIME  4   ticks spent in NS_YELLOW and in EW_YELLOW
//   CLEAR_TIME   2   ticks spent in each ALL_RED phase
//   PED_EXTRA    10  ticks added to EW_GREEN on a latched pedestrian request (PED_EXTEND_EN only)
// PORTS
//   clk           in   1           rising-edge clock
//   rst           in   1           synchronous, active-low reset (rst==0 resets on clk edge)
//   tick          in   1           one-cycle 1 Hz enable pulse
//   hold          in   1           freeze current phase and timer
//   ped_req       in   1           pedestrian button, level or pulse
//   tmr_count     in   COUNT_SIZE  current count returned by the countdown timer
//   tmr_load      out  1           load strobe to the timer
//   tmr_load_val  out  COUNT_SIZE  duration to load, valid when tmr_load=1
//   tmr_down      out  1           decrement enable to the timer
//   ns_light      out  3           {R,Y,G} one-hot, north-south
//   ew_light      out  3           {R,Y,G} one-hot, east-west
//   ped_walk      out  1           walk lamp; high during EW_GREEN when a request was served
// BEHAVIOUR
//   Phase cycle: ALL_RED_A -> NS_GREEN -> NS_YELLOW -> ALL_RED_B -> EW_GREEN -> EW_YELLOW -> ALL_RED_A.
//   Reset (rst==0 at edge): state=ALL_RED_A, armed=0, ped latch=0; ns_light=ew_light=3'b100,
//     tmr_load=0, tmr_down=0, ped_walk=0.
//   Entry cycle: the first cycle in any state (including the first cycle after reset release)
//     drives tmr_load=1 and tmr_load_val=that phase's duration; armed=0.
//   Next cycle: armed=1. Timer output is valid from this cycle (1-cycle timer latency).
//   tmr_down = tick & armed & ~hold. It is never asserted in the same cycle as tmr_load.
//   Advance: when armed & ~hold & tmr_count==0, the next state is registered. Phase length is
//     exactly N ticks, where N is the loaded duration.
//   Lights are decoded from the registered state only (no glitches, no lookahead).
//     Non-served road: 100. Served road: 001 (green) or 010 (yellow).
//   hold: state, armed and timer are frozen and lights are unchanged. hold beats a simultaneous expiry.
//     hold during an entry cycle does not suppress tmr_load.
//   tmr_count>0 with armed=0 is ignored; tmr_count==0 with armed=0 never advances.
//   Duration arithmetic is COUNT_SIZE wide. GREEN_TIME+PED_EXTRA must be < 2**COUNT_SIZE
//     (elaboration-time check). Every duration is >=1.
//   Reset mid-phase returns to ALL_RED_A on the same edge and discards the in-flight count.
// CONFIGURATION
//   PED_EXTEND_EN defined:
//     - ped_req sets a sticky latch in any state.
//     - On EW_GREEN entry with the latch set: load GREEN_TIME+PED_EXTRA, raise ped_walk for the
//       whole EW_GREEN, and clear the latch on that entry edge.
//     - A request arriving during that EW_GREEN is held for the next cycle.
//   PED_EXTEND_EN undefined: ped_req is ignored, ped_walk=0, EW_GREEN always loads GREEN_TIME.
// STRUCTURE
//   traffic_pkg: phase-state enum (3-bit), light constants LIGHT_R=3'b100, LIGHT_Y=3'b010,
//     LIGHT_G=3'b001.
//   Sub-module phase_duration_lut: combinational state(+ped latch) -> duration.
//   FSM, armed flag and ped latch stay in this module.
//   The timer itself is instantiated by the parent, not here.
// TESTING
//   - Bench pairs the DUT with the countdown timer; tick every 4 clk.
//   - Reset then release -> tmr_load=1 val=2 in the first cycle; both lights 100; NS_GREEN
//     entered after 2 ticks.
//   - Full cycle with defaults -> phase lengths 2/30/4/2/30/4 ticks; lights one-hot; never green
//     on both roads.
//   - hold asserted for 10 ticks mid NS_GREEN -> tmr_count is constant; the phase ends 10 ticks late.
//   - rst low while tmr_count=17 in EW_GREEN -> next cycle is ALL_RED_A, lights 100/100,
//     tmr_down=0.
//   - PED_EXTEND_EN, ped_req pulse in NS_YELLOW -> EW_GREEN loads 40, ped_walk=1 for 40 ticks.
//     The following EW_GREEN loads 30.
//   - PED_EXTEND_EN undefined, same stimulus -> EW_GREEN loads 30, ped_walk stays 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic phase sequencer:
// phase-state encoding, lamp patterns and the fixed phase order.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } phase_e;

    // Lamp patterns are {R,Y,G}
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    function automatic phase_e next_phase(input phase_e cur);
        phase_e nxt;
        case (cur)
            ALL_RED_A: nxt = NS_GREEN;
            NS_GREEN:  nxt = NS_YELLOW;
            NS_YELLOW: nxt = ALL_RED_B;
            ALL_RED_B: nxt = EW_GREEN;
            EW_GREEN:  nxt = EW_YELLOW;
            EW_YELLOW: nxt = ALL_RED_A;
            default:   nxt = ALL_RED_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/phase_duration_lut.sv
// Combinational phase -> timer load value lookup. The pedestrian extension
// input lengthens EW_GREEN only.
module phase_duration_lut
    import traffic_pkg::*;
#(
    parameter int COUNT_SIZE  = 7,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 4,
    parameter int CLEAR_TIME  = 2,
    parameter int PED_EXTRA   = 10
) (
    input  logic [2:0]            phase_i,
    input  logic                  ped_ext_i,
    output logic [COUNT_SIZE-1:0] duration_o
);

    localparam logic [COUNT_SIZE-1:0] DUR_GREEN  = COUNT_SIZE'(GREEN_TIME);
    localparam logic [COUNT_SIZE-1:0] DUR_EXT    = COUNT_SIZE'(GREEN_TIME + PED_EXTRA);
    localparam logic [COUNT_SIZE-1:0] DUR_YELLOW = COUNT_SIZE'(YELLOW_TIME);
    localparam logic [COUNT_SIZE-1:0] DUR_CLEAR  = COUNT_SIZE'(CLEAR_TIME);

    // Duration of the phase currently being entered
    always_comb begin
        duration_o = DUR_CLEAR;
        case (phase_i)
            ALL_RED_A: duration_o = DUR_CLEAR;
            NS_GREEN:  duration_o = DUR_GREEN;
            NS_YELLOW: duration_o = DUR_YELLOW;
            ALL_RED_B: duration_o = DUR_CLEAR;
            EW_GREEN: begin
                if (ped_ext_i) begin
                    duration_o = DUR_EXT;
                end else begin
                    duration_o = DUR_GREEN;
                end
            end
            EW_YELLOW: duration_o = DUR_YELLOW;
            default:   duration_o = DUR_CLEAR;
        endcase
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer driving an external countdown timer.
// Optional pedestrian green extension is enabled by defining PED_EXTEND_EN.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int COUNT_SIZE  = 7,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 4,
    parameter int CLEAR_TIME  = 2,
    parameter int PED_EXTRA   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  hold,
    input  logic                  ped_req,
    input  logic [COUNT_SIZE-1:0] tmr_count,
    output logic                  tmr_load,
    output logic [COUNT_SIZE-1:0] tmr_load_val,
    output logic                  tmr_down,
    output logic [2:0]            ns_light,
    output logic [2:0]            ew_light,
    output logic                  ped_walk
);

    if ((GREEN_TIME + PED_EXTRA) >= (1 << COUNT_SIZE)) begin : g_bad_ext
        $error("GREEN_TIME+PED_EXTRA does not fit in COUNT_SIZE bits");
    end
    if (GREEN_TIME < 1 || YELLOW_TIME < 1 || CLEAR_TIME < 1) begin : g_bad_min
        $error("every phase duration must be at least 1");
    end

    phase_e state_q, state_d;
    logic   armed_q, armed_d;
    logic   ped_q, ped_d;
    logic   walk_q, walk_d;
    logic   entry_s;
    logic   expired_s;
    phase_e nxt_s;

    // armed is low only in the first cycle of a phase, which is the load cycle
    assign entry_s   = ~armed_q;
    assign expired_s = armed_q & ~hold & (tmr_count == {COUNT_SIZE{1'b0}});
    assign nxt_s     = next_phase(state_q);

    // Next-state, armed flag and pedestrian bookkeeping
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        ped_d   = ped_q;
        walk_d  = walk_q;
        if (entry_s) begin
            armed_d = 1'b1;
        end else if (expired_s) begin
            state_d = nxt_s;
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
`ifdef PED_EXTEND_EN
        // A request is served on the edge that enters EW_GREEN, including one arriving on that edge
        if (expired_s && (nxt_s == EW_GREEN)) begin
            walk_d = ped_q | ped_req;
            ped_d  = 1'b0;
        end else if (expired_s) begin
            walk_d = 1'b0;
            ped_d  = ped_q | ped_req;
        end else begin
            walk_d = walk_q;
            ped_d  = ped_q | ped_req;
        end
`else
        walk_d = 1'b0;
        ped_d  = 1'b0;
`endif
    end

`ifndef PED_EXTEND_EN
    logic unused_ped_s;
    assign unused_ped_s = ped_req;
`endif

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ALL_RED_A;
            armed_q <= 1'b0;
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            ped_q   <= ped_d;
            walk_q  <= walk_d;
        end
    end

    phase_duration_lut #(
        .COUNT_SIZE (COUNT_SIZE),
        .GREEN_TIME (GREEN_TIME),
        .YELLOW_TIME(YELLOW_TIME),
        .CLEAR_TIME (CLEAR_TIME),
        .PED_EXTRA  (PED_EXTRA)
    ) u_lut (
        .phase_i   (state_q),
        .ped_ext_i (walk_q),
        .duration_o(tmr_load_val)
    );

    assign tmr_load = entry_s & rst;
    assign tmr_down = tick & armed_q & ~hold;
    assign ped_walk = walk_q;

    // Lamp decode from the registered phase only
    always_comb begin
        ns_light = LIGHT_R;
        ew_light = LIGHT_R;
        case (state_q)
            NS_GREEN:  ns_light = LIGHT_G;
            NS_YELLOW: ns_light = LIGHT_Y;
            EW_GREEN:  ew_light = LIGHT_G;
            EW_YELLOW: ew_light = LIGHT_Y;
            default: begin
                ns_light = LIGHT_R;
                ew_light = LIGHT_R;
            end
        endcase
    end

endmodule
